on_the_fly: RTL and testbench

Radix-4 on-the-fly quotient converter for the SRT divider datapath. Each cycle it accepts one signed quotient digit q ∈ {−2,−1,0,1,2} from the digit-selection stage. It folds the digit into a 24-bit non-redundant binary quotient using the Q/QM (Q minus one ulp) register pair. No carry-propagate adder is needed. After 12 digits, dout holds the final 24-bit fractional quotient.

---
 rtl/on_the_fly_pkg.sv | 19 +
 rtl/on_the_fly_digit_sel.sv | 43 ++++
 rtl/on_the_fly.sv | 63 ++++++
 tb/tb_on_the_fly.sv | 135 +++++++++++++
 4 files changed

// File: rtl/on_the_fly_pkg.sv
// Shared constants and types for the radix-4 on-the-fly quotient converter.
package on_the_fly_pkg;

   localparam int OTF_RADIX = 4;
   localparam int OTF_NDIG  = 12;
   localparam int OTF_W     = 2 * OTF_NDIG;

   // Signed quotient digit, legal range -2..+2.
   typedef logic signed [2:0] digit_t;

   // Per-digit decode produced by the digit selector.
   typedef struct packed {
      logic [1:0] q_fld;       // value written into field F of the new Q
      logic [1:0] qm_fld;      // value written into field F of the new QM
      logic       q_from_qm;   // new Q is built from QM (q < 0)
      logic       qm_from_qm;  // new QM is built from QM (q <= 0)
   } digit_sel_t;

endpackage

// File: rtl/on_the_fly_digit_sel.sv
// Combinational digit decode: maps (q, q_abs) to the field values and the
// source selects for the Q/QM update. Illegal digits still only produce a
// 2-bit field value, so they can never disturb bits outside field F.
module on_the_fly_digit_sel
   import on_the_fly_pkg::*;
(
   input  digit_t     q,
   input  logic [2:0] q_abs,
   output digit_sel_t sel
);

   logic [2:0] q_neg_fld;
   logic [2:0] qm_neg_fld;
   logic [1:0] q_pos_m1;

   // Decode the digit into field values and register-source selects.
   always_comb begin
      sel        = '0;
      q_neg_fld  = 3'd4 - q_abs;
      qm_neg_fld = 3'd3 - q_abs;
      q_pos_m1   = q[1:0] - 2'd1;
      if (q[2]) begin
         // Negative digit: borrow from QM.
         sel.q_fld      = q_neg_fld[1:0];
         sel.qm_fld     = qm_neg_fld[1:0];
         sel.q_from_qm  = 1'b1;
         sel.qm_from_qm = 1'b1;
      end else if (q == 3'sd0) begin
         // Zero digit: Q extends with 0, QM extends with 3 (all ones).
         sel.q_fld      = 2'd0;
         sel.qm_fld     = 2'd3;
         sel.q_from_qm  = 1'b0;
         sel.qm_from_qm = 1'b1;
      end else begin
         // Positive digit: both registers are derived from Q.
         sel.q_fld      = q[1:0];
         sel.qm_fld     = q_pos_m1;
         sel.q_from_qm  = 1'b0;
         sel.qm_from_qm = 1'b0;
      end
   end

endmodule

// File: rtl/on_the_fly.sv
// Radix-4 on-the-fly quotient converter. Holds the Q/QM register pair and
// inserts one 2-bit digit field per enabled cycle, MSB field first.
// Only radix 4 is supported; RADIX is carried for interface compatibility.
module on_the_fly
   import on_the_fly_pkg::*;
#(
   parameter int RADIX = OTF_RADIX,
   parameter int NDIG  = OTF_NDIG,
   parameter int W     = OTF_W
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         CE,
   input  digit_t       q,
   input  logic [2:0]   q_abs,
   input  logic [3:0]   pointer,
   output logic [W-1:0] dout
);

   localparam logic [3:0] LAST_PTR = 4'(NDIG - 1);

   logic [W-1:0] q_r;
   logic [W-1:0] qm_r;
   logic [W-1:0] q_next;
   logic [W-1:0] qm_next;
   digit_sel_t   sel;
   logic         upd;

   on_the_fly_digit_sel u_digit_sel (
      .q     (q),
      .q_abs (q_abs),
      .sel   (sel)
   );

   // Pointers 12..15 are out of range and leave both registers untouched.
   assign upd = CE && (pointer <= LAST_PTR);

   // Copy the selected source register whole, then overwrite field F only.
   always_comb begin
      q_next  = sel.q_from_qm  ? qm_r : q_r;
      qm_next = sel.qm_from_qm ? qm_r : q_r;
      for (int k = 0; k < NDIG; k++) begin
         if (pointer == 4'(k)) begin
            q_next[W-1-2*k -: 2]  = sel.q_fld;
            qm_next[W-1-2*k -: 2] = sel.qm_fld;
         end
      end
   end

   // Register pair: reset clears both, CE gates the update.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         q_r  <= '0;
         qm_r <= '0;
      end else if (upd) begin
         q_r  <= q_next;
         qm_r <= qm_next;
      end
   end

   assign dout = q_r;

endmodule

// File: tb/tb_on_the_fly.sv
// Directed bench for the on-the-fly quotient converter.
module tb_on_the_fly;

   logic        CLK;
   logic        nRST;
   logic        CE;
   logic [2:0]  q;
   logic [2:0]  q_abs;
   logic [3:0]  pointer;
   logic [23:0] dout;

   int n_checks = 0;
   int n_errors = 0;

   // Main digit sequence and the hand-computed quotient after each digit.
   int          seq_d [12] = '{0, 2, -2, 0, 1, -2, 2, -1, -1, -2, 1, 0};
   logic [23:0] seq_e [12] = '{24'h000000, 24'h200000, 24'h180000, 24'h180000,
                               24'h184000, 24'h182000, 24'h182800, 24'h182700,
                               24'h1826C0, 24'h1826A0, 24'h1826A4, 24'h1826A4};

   on_the_fly dut (
      .CLK     (CLK),
      .nRST    (nRST),
      .CE      (CE),
      .q       (q),
      .q_abs   (q_abs),
      .pointer (pointer),
      .dout    (dout)
   );

   // Clock generation.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Drive one cycle of inputs on the falling edge, return just after the rising edge.
   task automatic drive(input logic rst, input logic ce, input int d, input int p);
      @(negedge CLK);
      nRST    = rst;
      CE      = ce;
      q       = 3'(d);
      q_abs   = 3'(-d);
      pointer = 4'(p);
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [23:0] exp);
      n_checks++;
      assert (dout === exp) else begin
         n_errors++;
         $error("FAIL %s: dout=%h expected=%h", tag, dout, exp);
      end
   endtask

   initial begin
      nRST = 1'b1; CE = 1'b0; q = '0; q_abs = '0; pointer = '0;

      // Reset with arbitrary digit and pointer.
      drive(1'b1, 1'b1, 2, 5);
      check("reset", 24'h000000);

      // Full reference conversion, checked after every digit.
      for (int j = 0; j < 12; j++) begin
         drive(1'b0, 1'b1, seq_d[j], j);
         check($sformatf("seq_d%0d", j), seq_e[j]);
      end

      // Out-of-range pointers hold the result.
      drive(1'b0, 1'b1, 2, 12);
      check("ptr12", 24'h1826A4);
      drive(1'b0, 1'b1, -2, 13);
      check("ptr13", 24'h1826A4);
      drive(1'b0, 1'b1, 1, 14);
      check("ptr14", 24'h1826A4);
      drive(1'b0, 1'b1, -1, 15);
      check("ptr15", 24'h1826A4);

      // All +2 digits.
      drive(1'b1, 1'b0, 0, 0);
      check("reset2", 24'h000000);
      drive(1'b0, 1'b1, 2, 0);
      check("p2_d0", 24'h800000);
      for (int j = 1; j < 12; j++) drive(1'b0, 1'b1, 2, j);
      check("p2_final", 24'hAAAAAA);

      // Reset must clear QM too: a negative first digit copies QM.
      drive(1'b1, 1'b1, 0, 3);
      check("reset3", 24'h000000);
      drive(1'b0, 1'b1, -1, 0);
      check("qm_clr_d0", 24'hC00000);
      drive(1'b0, 1'b1, -2, 1);
      check("qm_clr_d1", 24'hA00000);

      // +1 then -2: 1/4 - 2/16 = 1/8.
      drive(1'b1, 1'b0, 0, 0);
      drive(1'b0, 1'b1, 1, 0);
      check("short_d0", 24'h400000);
      drive(1'b0, 1'b1, -2, 1);
      check("short_d1", 24'h200000);

      // CE stall mid-sequence with toggling inputs.
      drive(1'b1, 1'b0, 0, 0);
      for (int j = 0; j < 5; j++) drive(1'b0, 1'b1, seq_d[j], j);
      check("stall_pre", 24'h184000);
      drive(1'b0, 1'b0, -2, 5);
      check("stall_c0", 24'h184000);
      drive(1'b0, 1'b0, 2, 0);
      check("stall_c1", 24'h184000);
      drive(1'b0, 1'b0, -1, 9);
      check("stall_c2", 24'h184000);
      for (int j = 5; j < 12; j++) drive(1'b0, 1'b1, seq_d[j], j);
      check("stall_final", 24'h1826A4);

      // Reset mid-sequence at pointer 5 wins over CE, then restart.
      drive(1'b1, 1'b0, 0, 0);
      for (int j = 0; j < 5; j++) drive(1'b0, 1'b1, seq_d[j], j);
      drive(1'b1, 1'b1, seq_d[5], 5);
      check("mid_reset", 24'h000000);
      for (int j = 0; j < 12; j++) drive(1'b0, 1'b1, seq_d[j], j);
      check("restart_final", 24'h1826A4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
